uart_reply_encoder: RTL and testbench
=====================================

UART_REPLY_ENCODER -- requirements
Module: uart_reply_encoder

Interface
REQ-001 Parameter REPLY_COMMAND, default 8'h81, is the command byte that opens every reply frame.
REQ-002 clock_12mhz  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clock_12mhz upstream.
REQ-004 read_request  input  1  single-cycle pulse requesting readback of one LED word.
REQ-005 read_address  input  9  LED address; sampled only in the cycle read_request is high.
REQ-006 mem_read_enable  output  1  one-cycle memory read strobe.
REQ-007 mem_read_address  output  9  memory address; valid while mem_read_enable is high.
REQ-008 mem_read_data  input  24  memory data; valid the cycle after mem_read_enable.
REQ-009 tx_data  output  8  byte to the UART transmitter; valid while tx_start is high.
REQ-010 tx_start  output  1  one-cycle pulse handing tx_data to the transmitter.
REQ-011 tx_busy  input  1  transmitter busy; goes high the cycle after tx_start and stays high until the byte has shifted out.
REQ-012 busy  output  1  high while a reply frame is in progress.
REQ-013 frame_done  output  1  one-cycle pulse when the last frame byte completes.
REQ-014 request_dropped  output  1  one-cycle pulse when read_request arrives while busy.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, LATCH, SEND, HOLD, WAIT.
- IDLE: read_request=1 -> latch read_address, clear byte index, go to FETCH.
- FETCH: assert mem_read_enable for one cycle -> LATCH.
- LATCH: capture mem_read_data[23:0] -> SEND.
- SEND: if tx_busy=0, pulse tx_start with current byte and go to HOLD; otherwise stay in SEND.
- HOLD: one cycle, tx_busy ignored -> WAIT.
- WAIT: on tx_busy=0, go to SEND if index<6 (after increment), else to IDLE with frame_done.
REQ-016 The frame SHALL be 7 bytes in this order:
- REPLY_COMMAND
- {7'b0, addr[8]}
- addr[7:0]
- data[23:16]
- data[15:8]
- data[7:0]
- checksum = XOR of bytes 0-5
REQ-017 The checksum SHALL accumulate with 8-bit XOR as bytes are issued; no carry; the accumulator is cleared in IDLE on an accepted request.
REQ-018 Latency SHALL be fixed: request in cycle N -> mem_read_enable in N+1 -> data capture in N+2 -> earliest first tx_start in N+3.
REQ-019 busy SHALL be high from cycle N+1 until the cycle after frame_done, inclusive of the frame_done cycle.
REQ-020 read_request while busy=1 SHALL be ignored and SHALL pulse request_dropped in the following cycle; the frame in progress is unaffected.
REQ-021 read_request in the same cycle as frame_done SHALL be dropped; a request is accepted only in IDLE.
REQ-022 tx_start SHALL never be asserted while tx_busy=1 and never in two consecutive cycles.
REQ-023 The byte index SHALL be 3 bits, SHALL count 0-6, and SHALL never wrap; at index 6 completion the FSM returns to IDLE.
REQ-024 tx_data SHALL hold its last value when tx_start is low.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE and set mem_read_enable, tx_start, busy, frame_done and request_dropped to 0.
REQ-026 Under reset_n=0, tx_data, mem_read_address, the latched address/data, the index and the checksum SHALL all be 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release no byte is sent until a new read_request.

Verification
REQ-028 Basic read: addr 9'h005, memory 24'h123456, tx_busy model 10 cycles -> tx_data sequence 81,00,05,12,34,56,F4; one frame_done; busy low afterwards.
REQ-029 High address: addr 9'h1FF, data 24'h000000 -> bytes 81,01,FF,00,00,00,7F.
REQ-030 Latency: tx_busy held 0, request at cycle N -> mem_read_enable at N+1 only; first tx_start at N+3.
REQ-031 Back-pressure: tx_busy held high for 50 cycles before byte 3 -> no tx_start while tx_busy=1; frame bytes unchanged.
REQ-032 Overlap: second read_request during byte 2 and another in the frame_done cycle -> two request_dropped pulses; only one frame sent.
REQ-033 Reset mid-frame: reset_n low after byte 4 -> all outputs 0 at once; no tx_start after release; a new request yields a complete correct frame.

Source files
------------

// File: rtl/uart_reply_encoder.sv
// Reads one 24-bit LED word from memory and sends it back as a 7-byte UART reply frame.
module uart_reply_encoder #(
  parameter logic [7:0] REPLY_COMMAND = 8'h81
) (
  input  logic        clock_12mhz,
  input  logic        reset_n,
  input  logic        read_request,
  input  logic [8:0]  read_address,
  output logic        mem_read_enable,
  output logic [8:0]  mem_read_address,
  input  logic [23:0] mem_read_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_done,
  output logic        request_dropped
);

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    idx_q;
  logic [BYTE_W-1:0]   chk_q;
  logic [BYTE_W-1:0]   tx_last_q;
  logic [BYTE_W-1:0]   cur_byte;
  logic                accept;
  logic                advance;

  assign accept           = (state_q == ST_IDLE) && read_request;
  assign advance          = (state_q == ST_WAIT) && !tx_busy && (idx_q != LAST_IDX);
  assign mem_read_address = addr_q;

  // State register.
  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (read_request) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_SEND;
      ST_SEND:  if (!tx_busy) state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_WAIT;
      ST_WAIT:  if (!tx_busy) state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_SEND;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Frame byte selected by the current index.
  always_comb begin
    cur_byte = '0;
    case (idx_q)
      3'd0:    cur_byte = REPLY_COMMAND;
      3'd1:    cur_byte = {{(BYTE_W-1){1'b0}}, addr_q[ADDR_W-1]};
      3'd2:    cur_byte = addr_q[BYTE_W-1:0];
      3'd3:    cur_byte = data_q[23:16];
      3'd4:    cur_byte = data_q[15:8];
      3'd5:    cur_byte = data_q[7:0];
      3'd6:    cur_byte = chk_q;
      default: cur_byte = '0;
    endcase
  end

  // Outputs; tx_start/frame_done react to tx_busy in the same cycle so a start never lands on a busy transmitter.
  always_comb begin
    mem_read_enable = 1'b0;
    tx_start        = 1'b0;
    busy            = 1'b0;
    frame_done      = 1'b0;
    tx_data         = tx_last_q;
    case (state_q)
      ST_IDLE:  busy = 1'b0;
      ST_FETCH: begin
        busy            = 1'b1;
        mem_read_enable = 1'b1;
      end
      ST_LATCH: busy = 1'b1;
      ST_SEND: begin
        busy     = 1'b1;
        tx_start = !tx_busy;
        if (!tx_busy) tx_data = cur_byte;
      end
      ST_HOLD:  busy = 1'b1;
      ST_WAIT: begin
        busy       = 1'b1;
        frame_done = !tx_busy && (idx_q == LAST_IDX);
      end
      default:  busy = 1'b0;
    endcase
  end

  // Frame datapath: latched address/data, byte index, running checksum, last sent byte, drop flag.
  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      addr_q          <= '0;
      data_q          <= '0;
      idx_q           <= '0;
      chk_q           <= '0;
      tx_last_q       <= '0;
      request_dropped <= 1'b0;
    end else begin
      request_dropped <= read_request && (state_q != ST_IDLE);
      if (accept) begin
        addr_q <= read_address;
        idx_q  <= '0;
        chk_q  <= '0;
      end
      if (state_q == ST_LATCH) data_q <= mem_read_data;
      if (tx_start) begin
        tx_last_q <= cur_byte;
        if (idx_q != LAST_IDX) chk_q <= chk_q ^ cur_byte;
      end
      if (advance) idx_q <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_reply_encoder.sv
// Scoreboard bench for uart_reply_encoder: random frames plus directed latency, back-pressure, overlap and reset cases.
module tb_uart_reply_encoder;

  logic        clock_12mhz = 1'b0;
  logic        reset_n;
  logic        read_request;
  logic [8:0]  read_address;
  logic        mem_read_enable;
  logic [8:0]  mem_read_address;
  logic [23:0] mem_read_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        frame_done;
  logic        request_dropped;

  uart_reply_encoder #(.REPLY_COMMAND(8'h81)) dut (
    .clock_12mhz      (clock_12mhz),
    .reset_n          (reset_n),
    .read_request     (read_request),
    .read_address     (read_address),
    .mem_read_enable  (mem_read_enable),
    .mem_read_address (mem_read_address),
    .mem_read_data    (mem_read_data),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .tx_busy          (tx_busy),
    .busy             (busy),
    .frame_done       (frame_done),
    .request_dropped  (request_dropped)
  );

  initial forever #5 clock_12mhz = ~clock_12mhz;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [8:0]  exp_addr_q[$];
  int          bytes_sent = 0;
  int          frames_seen = 0;
  int          frames_exp = 0;
  int          dropped_seen = 0;
  int          dropped_exp = 0;
  int          busy_len = 0;
  bit          hold_busy = 1'b0;
  logic [23:0] mem [512];
  logic [7:0]  last_byte = '0;
  bit          prev_start = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference frame: command, address high bit, address low byte, data bytes, XOR of the six.
  task automatic push_frame(input logic [8:0] addr);
    logic [7:0]  b [7];
    logic [23:0] d;
    d    = mem[addr];
    b[0] = 8'h81;
    b[1] = {7'b0, addr[8]};
    b[2] = addr[7:0];
    b[3] = d[23:16];
    b[4] = d[15:8];
    b[5] = d[7:0];
    b[6] = 8'h00;
    for (int i = 0; i < 6; i++) b[6] = b[6] ^ b[i];
    for (int i = 0; i < 7; i++) exp_q.push_back(b[i]);
    exp_addr_q.push_back(addr);
    frames_exp++;
  endtask

  task automatic issue(input logic [8:0] addr);
    @(negedge clock_12mhz); #1;
    read_request = 1'b1;
    read_address = addr;
    push_frame(addr);
    @(negedge clock_12mhz); #1;
    read_request = 1'b0;
    read_address = 9'($urandom);
  endtask

  task automatic pulse_drop();
    @(negedge clock_12mhz); #1;
    read_request = 1'b1;
    read_address = 9'($urandom);
    dropped_exp++;
    @(negedge clock_12mhz); #1;
    read_request = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clock_12mhz); #4;
      n++;
    end
    cmp({name, "_timeout"}, 32'(n < 3000), 32'd1);
    cmp({name, "_busy_after"}, 32'(busy), 32'd0);
    cmp({name, "_frames"}, 32'(frames_seen), 32'(frames_exp));
  endtask

  task automatic wait_bytes(input int target, input string name);
    int n = 0;
    while (bytes_sent < target && n < 2000) begin
      @(negedge clock_12mhz); #4;
      n++;
    end
    cmp({name, "_byte_timeout"}, 32'(n < 2000), 32'd1);
  endtask

  // Transmitter model: busy the cycle after each start for busy_len cycles, or while hold_busy is set.
  initial begin
    int  busy_cnt;
    bit  start_seen;
    busy_cnt   = 0;
    start_seen = 1'b0;
    tx_busy    = 1'b0;
    forever begin
      @(negedge clock_12mhz); #1;
      if (busy_cnt > 0) busy_cnt--;
      if (start_seen) busy_cnt = busy_len;
      tx_busy = (busy_cnt != 0) || hold_busy;
      #2;
      start_seen = tx_start;
    end
  end

  // Memory model: data appears only in the cycle after the read strobe, random otherwise.
  initial begin
    bit         pend;
    logic [8:0] pend_addr;
    pend          = 1'b0;
    pend_addr     = '0;
    mem_read_data = '0;
    forever begin
      @(negedge clock_12mhz); #1;
      mem_read_data = pend ? mem[pend_addr] : 24'($urandom);
      #2;
      pend      = mem_read_enable;
      pend_addr = mem_read_address;
    end
  end

  // Monitor: pops the scoreboard on every tx_start and on every memory strobe.
  initial begin
    forever begin
      @(negedge clock_12mhz); #3;
      if (!reset_n) begin
        prev_start = 1'b0;
        last_byte  = '0;
      end else begin
        if (mem_read_enable) begin
          if (exp_addr_q.size() == 0) cmp("unexpected_mem_read", 32'd1, 32'd0);
          else cmp("mem_read_address", 32'(mem_read_address), 32'(exp_addr_q.pop_front()));
        end
        if (tx_start) begin
          cmp("tx_start_while_busy", 32'(tx_busy), 32'd0);
          cmp("tx_start_back_to_back", 32'(prev_start), 32'd0);
          if (exp_q.size() == 0) cmp("unexpected_tx_byte", 32'(tx_data) + 32'h100, 32'd0);
          else cmp("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          last_byte = tx_data;
          bytes_sent++;
        end else begin
          cmp("tx_data_hold", 32'(tx_data), 32'(last_byte));
        end
        if (frame_done) begin
          frames_seen++;
          cmp("frame_done_early", 32'(exp_q.size()), 32'd0);
        end
        if (request_dropped) dropped_seen++;
        prev_start = tx_start;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    int  n;
    reset_n      = 1'b0;
    read_request = 1'b0;
    read_address = '0;
    for (int i = 0; i < 512; i++) mem[i] = 24'($urandom);

    repeat (3) @(negedge clock_12mhz);
    #4;
    cmp("rst_mem_read_enable", 32'(mem_read_enable), 32'd0);
    cmp("rst_tx_start", 32'(tx_start), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_frame_done", 32'(frame_done), 32'd0);
    cmp("rst_request_dropped", 32'(request_dropped), 32'd0);
    cmp("rst_tx_data", 32'(tx_data), 32'd0);
    cmp("rst_mem_read_address", 32'(mem_read_address), 32'd0);
    @(negedge clock_12mhz); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clock_12mhz);

    // Basic read, expected bytes 81,00,05,12,34,56,F4.
    mem[9'h005] = 24'h123456;
    busy_len = 10;
    issue(9'h005);
    wait_frame("basic");

    // High address, expected bytes 81,01,FF,00,00,00,7F.
    mem[9'h1FF] = 24'h000000;
    busy_len = 3;
    issue(9'h1FF);
    wait_frame("high_addr");

    // Fixed latency with an idle transmitter.
    busy_len = 0;
    @(negedge clock_12mhz); #1;
    read_request = 1'b1;
    read_address = 9'h0A3;
    push_frame(9'h0A3);
    #2;
    cmp("lat_n_mre", 32'(mem_read_enable), 32'd0);
    cmp("lat_n_busy", 32'(busy), 32'd0);
    @(negedge clock_12mhz); #1;
    read_request = 1'b0;
    read_address = 9'h155;
    #2;
    cmp("lat_n1_mre", 32'(mem_read_enable), 32'd1);
    cmp("lat_n1_busy", 32'(busy), 32'd1);
    @(negedge clock_12mhz); #3;
    cmp("lat_n2_mre", 32'(mem_read_enable), 32'd0);
    cmp("lat_n2_tx_start", 32'(tx_start), 32'd0);
    @(negedge clock_12mhz); #3;
    cmp("lat_n3_tx_start", 32'(tx_start), 32'd1);
    wait_frame("latency");

    // Back-pressure: transmitter stays busy for 50 cycles before byte 3.
    busy_len = 2;
    base = bytes_sent;
    issue(9'($urandom));
    wait_bytes(base + 3, "bp");
    hold_busy = 1'b1;
    repeat (50) @(negedge clock_12mhz);
    #4;
    cmp("bp_stalled_bytes", 32'(bytes_sent), 32'(base + 3));
    hold_busy = 1'b0;
    wait_frame("backpressure");

    // Overlap: request during byte 2 and another in the frame_done cycle are both dropped.
    busy_len = 3;
    base = bytes_sent;
    issue(9'($urandom));
    wait_bytes(base + 3, "ovl");
    pulse_drop();
    n = 0;
    do begin
      @(negedge clock_12mhz); #2;
      n++;
    end while (!frame_done && n < 2000);
    cmp("ovl_frame_done_seen", 32'(frame_done), 32'd1);
    read_request = 1'b1;
    read_address = 9'($urandom);
    dropped_exp++;
    @(negedge clock_12mhz); #1;
    read_request = 1'b0;
    repeat (20) @(negedge clock_12mhz);
    #4;
    cmp("ovl_dropped", 32'(dropped_seen), 32'(dropped_exp));
    cmp("ovl_frames", 32'(frames_seen), 32'(frames_exp));
    cmp("ovl_busy", 32'(busy), 32'd0);
    cmp("ovl_bytes", 32'(bytes_sent), 32'(base + 7));

    // Reset after byte 4 abandons the frame.
    busy_len = 4;
    base = bytes_sent;
    issue(9'($urandom));
    wait_bytes(base + 5, "mid_rst");
    @(negedge clock_12mhz); #1;
    reset_n = 1'b0;
    #1;
    cmp("mid_rst_mre", 32'(mem_read_enable), 32'd0);
    cmp("mid_rst_tx_start", 32'(tx_start), 32'd0);
    cmp("mid_rst_busy", 32'(busy), 32'd0);
    cmp("mid_rst_frame_done", 32'(frame_done), 32'd0);
    cmp("mid_rst_request_dropped", 32'(request_dropped), 32'd0);
    cmp("mid_rst_tx_data", 32'(tx_data), 32'd0);
    cmp("mid_rst_mem_read_address", 32'(mem_read_address), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    frames_exp--;
    repeat (3) @(negedge clock_12mhz);
    #1;
    reset_n = 1'b1;
    base = bytes_sent;
    repeat (30) @(negedge clock_12mhz);
    #4;
    cmp("post_rst_no_bytes", 32'(bytes_sent), 32'(base));
    cmp("post_rst_busy", 32'(busy), 32'd0);
    issue(9'($urandom));
    wait_frame("post_reset");

    // Random frames with random transmitter speed.
    repeat (15) begin
      busy_len = int'($urandom_range(0, 12));
      issue(9'($urandom));
      wait_frame("random");
    end
    cmp("final_dropped", 32'(dropped_seen), 32'(dropped_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
